// File: rtl/idexe_skid.sv
// ---------------------------------------------------------------------------
// idexe_skid
//   ID/EXE pipeline stage with a valid/ready handshake and a one-entry skid
//   buffer. A bundle of NL lanes (DW bits each) moves from decode to execute.
//   A downstream stall parks at most one extra bundle in the skid register, so
//   in_ready is a plain flop output with no path from out_ready. A synchronous
//   flush empties the stage, leaving zero bubbles. Two saturating counters
//   record stall cycles and discarded bundles.
//
// Ports
//   clk        rising-edge clock
//   Reset      asynchronous active-low reset
//   flush      discard all stage contents at the next edge
//   in_valid   upstream bundle valid
//   in_ready   stage can accept a bundle this cycle (= ~skid_v)
//   in_data    upstream bundle, lane k at [k*DW +: DW]
//   out_valid  out_data valid (= main_v)
//   out_ready  downstream consumes this cycle
//   out_data   main register contents
//   cnt_clr    synchronous clear of both counters (wins over increment)
//   stall_cnt  cycles with out_valid=1 and out_ready=0, saturating
//   flush_cnt  bundles discarded by flush, saturating
// ---------------------------------------------------------------------------
module idexe_skid #(
  parameter int DW = 32,
  parameter int NL = 6,
  parameter int CW = 16
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [NL*DW-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [NL*DW-1:0] out_data,
  input  logic             cnt_clr,
  output logic [CW-1:0]    stall_cnt,
  output logic [CW-1:0]    flush_cnt
);

  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  logic             main_v;
  logic             skid_v;
  logic [NL*DW-1:0] main_d;
  logic [NL*DW-1:0] skid_d;

  logic             acc;
  logic             take;
  logic             main_free;
  logic [1:0]       flush_inc;
  logic [CW:0]      flush_sum;

  // All three handshake-facing outputs are direct flop outputs.
  assign out_valid = main_v;
  assign out_data  = main_d;
  assign in_ready  = ~skid_v;

  assign acc       = in_valid & in_ready;
  assign take      = main_v & out_ready;
  assign main_free = ~main_v | take;

  // Bundles lost to a flush: both stored entries plus one accepted this cycle.
  // A take in the flush cycle still counts, since main_v is still set.
  assign flush_inc = {1'b0, main_v} + {1'b0, skid_v} + {1'b0, acc};
  assign flush_sum = {1'b0, flush_cnt} + {{(CW-1){1'b0}}, flush_inc};

  // NOTE: sequential state is updated only with non-blocking assignments so
  // every flop samples the pre-edge values, regardless of statement order.
  // NOTE: the data registers are reset as well; a flushed or reset stage
  // presents all-zero data, and downstream logic may rely on that.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
      main_d <= '0;
      skid_d <= '0;
    end else if (flush) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
      main_d <= '0;
      skid_d <= '0;
    end else if (main_free) begin
      if (skid_v) begin
        // Skid entry is older than anything upstream; in_ready is low so acc=0.
        main_d <= skid_d;
        main_v <= 1'b1;
        skid_d <= '0;
        skid_v <= 1'b0;
      end else if (acc) begin
        main_d <= in_data;
        main_v <= 1'b1;
      end else begin
        main_d <= '0;
        main_v <= 1'b0;
      end
    end else if (acc) begin
      // Main stalled: park the new bundle; in_ready drops next cycle.
      skid_d <= in_data;
      skid_v <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      stall_cnt <= '0;
    end else if (cnt_clr) begin
      stall_cnt <= '0;
    end else if (main_v && !out_ready && stall_cnt != CNT_MAX) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      flush_cnt <= '0;
    end else if (cnt_clr) begin
      flush_cnt <= '0;
    end else if (flush) begin
      flush_cnt <= flush_sum[CW] ? CNT_MAX : flush_sum[CW-1:0];
    end
  end

endmodule

// File: doc/idexe_skid.md
Name: idexe_skid

Overview:
- Parametrised successor to the ID/EXE pipeline register.
- Carries NL data lanes of DW bits between decode and execute, with a valid/ready handshake instead of a hold/flush code.
- Includes a one-entry skid buffer, so a downstream stall never drops or duplicates a transfer and in_ready has no combinational path from out_ready.
- Provides a synchronous flush that inserts zero bubbles, plus saturating stall and flush counters for profiling.

Parameters:
- DW, 32, width of one lane in bits.
- NL, 6, number of lanes (instruction, operand A, operand B, forwarded ALU result, forwarded shift result, PC).
- CW, 16, width of each performance counter.

Ports:
- clk, input, 1: rising-edge clock.
- Reset, input, 1: asynchronous active-low reset.
- flush, input, 1: discards all stage contents at the next clock edge.
- in_valid, input, 1: upstream holds a valid bundle.
- in_ready, output, 1: stage accepts a bundle this cycle.
- in_data, input, NL*DW: upstream bundle; lane k is bits [k*DW +: DW].
- out_valid, output, 1: out_data is valid.
- out_ready, input, 1: downstream consumes this cycle.
- out_data, output, NL*DW: main register contents.
- cnt_clr, input, 1: synchronous clear of both counters.
- stall_cnt, output, CW: cycles with out_valid=1 and out_ready=0.
- flush_cnt, output, CW: bundles discarded by flush.

Behaviour:
- Reset is asynchronous on Reset=0.
  - Reset forces main_v=0 and skid_v=0, and zeroes main data, skid data, stall_cnt and flush_cnt.
  - After reset, in_ready=1.
- Storage consists of the main register (main_v, main_d) and the skid register (skid_v, skid_d).
- Output mapping: out_valid=main_v, out_data=main_d, in_ready=~skid_v. All three come straight from flops with no combinational logic.
- Handshakes:
  - acc = in_valid & in_ready.
  - take = out_valid & out_ready.
  - in_data is sampled only when acc=1.
- Priority at each rising edge is flush, then normal operation.
- Flush (flush=1):
  - main_v and skid_v are cleared; main_d and skid_d are zeroed.
  - A bundle accepted in the same cycle (acc=1) is discarded.
  - flush_cnt += main_v + skid_v + acc, saturating.
  - A take in the flush cycle still completes downstream; that bundle is counted as discarded anyway.
- Normal operation, main free (main_v=0 or take=1):
  - If skid_v=1: main_d<=skid_d, main_v<=1, skid_v<=0, skid_d<=0. In this case acc=0, because in_ready=0.
  - Else if acc=1: main_d<=in_data, main_v<=1.
  - Else: main_v<=0, main_d<=0 (zero bubble).
- Normal operation, main stalled (main_v=1 and take=0):
  - If acc=1: skid_d<=in_data, skid_v<=1. in_ready falls on the next cycle.
  - Otherwise hold.
- Latency and throughput:
  - Latency is one cycle from acc to out_valid.
  - Sustained throughput is 1 bundle/cycle while out_ready=1.
  - At most 2 bundles are in flight.
- Ordering: strict FIFO order is kept; the skid entry always leaves before any newer input.
- stall_cnt:
  - Increments when out_valid=1 and out_ready=0.
  - Saturates at 2^CW-1.
  - cnt_clr has priority over increment: the counter becomes 0 that cycle and the event is lost.
- flush_cnt follows the same clear and saturation rules as stall_cnt.
- Lane widths are independent; no arithmetic is performed on data.
- Reset mid-transfer: any pending bundle is lost with no output pulse.

Test Plan:
- Reset then stream: hold Reset=0 for 2 cycles, release, then present bundles 1..4 (lane0=1..4, other lanes=lane0<<4) with out_ready=1. Required: in_ready=1 throughout; out_data lane0 shows 1,2,3,4 on consecutive cycles, each one cycle after acceptance; stall_cnt=0.
- Backpressure: load A, drop out_ready, offer B and C. Required: B is captured in skid and in_ready=0 the next cycle; C is held upstream. Raise out_ready: output sequence is A,B,C with no loss or duplication; stall_cnt equals the number of cycles out_ready was low while out_valid=1.
- Flush with full stage: main and skid both valid, in_valid=1, in_ready=0, then flush=1. Required: the next cycle has out_valid=0, out_data=0 and in_ready=1; flush_cnt=2.
- Flush with acceptance: main valid, skid empty, in_valid=1, flush=1. Required: flush_cnt increases by 2; the incoming bundle never appears at the output.
- Saturation and clear: with CW=4, stall for 20 cycles. Required: stall_cnt=15 and stays there. Then pulse cnt_clr while still stalled. Required: stall_cnt=0 that edge, then 1 the next cycle.
- Asynchronous reset mid-operation: assert Reset between clock edges with main and skid full. Required: out_valid=0, in_ready=1 and out_data=0 immediately, without waiting for a clock edge; counters are zero.
